// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares the pipelined main memory between instruction fetch (I) and load/store (D).
// Define MEM_ARB_PERF_EN to add the grant and conflict performance counters.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_LATENCY     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_req_valid_i,
  output logic                  i_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic [1:0]            i_access_size_i,
  output logic                  i_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] i_rsp_data_o,
  input  logic                  d_req_valid_i,
  input  logic                  d_req_we_i,
  output logic                  d_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wr_data_i,
  input  logic [1:0]            d_access_size_i,
  output logic                  d_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] d_rsp_data_o,
  output logic                  mem_rd_req_valid_o,
  output logic                  mem_wr_req_valid_o,
  output logic                  mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [1:0]            mem_access_size_o,
  input  logic                  mem_data_valid_i,
  input  logic                  mem_data_is_instr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_i_grants_o,
  output logic [31:0]           perf_d_grants_o,
  output logic [31:0]           perf_conflicts_o
`endif
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {LAST_I = 1'b0, LAST_D = 1'b1} last_e;

  last_e            last_q, last_d;
  logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic             i_elig, d_elig, i_gnt, d_gnt, i_rsp, d_rsp, d_rd_gnt;

  // Eligibility uses registered counts, so a response arriving this cycle frees its credit only next cycle.
  assign i_elig   = rst_i & i_req_valid_i & (i_cnt_q < CNT_MAX);
  assign d_elig   = rst_i & d_req_valid_i & (d_req_we_i | (d_cnt_q < CNT_MAX));
  assign i_gnt    = i_elig & (~d_elig | (last_q == LAST_D));
  assign d_gnt    = d_elig & ~i_gnt;
  assign d_rd_gnt = d_gnt & ~d_req_we_i;

  assign i_rsp = rst_i & mem_data_valid_i & mem_data_is_instr_i;
  assign d_rsp = rst_i & mem_data_valid_i & ~mem_data_is_instr_i;

  assign i_req_ready_o = i_gnt;
  assign d_req_ready_o = d_gnt;
  assign i_rsp_valid_o = i_rsp;
  assign d_rsp_valid_o = d_rsp;
  assign i_rsp_data_o  = mem_data_i;
  assign d_rsp_data_o  = mem_data_i;

  always_comb begin
    mem_rd_req_valid_o = i_gnt | d_rd_gnt;
    mem_wr_req_valid_o = d_gnt & d_req_we_i;
    mem_req_is_instr_o = i_gnt;
    mem_address_o      = d_addr_i;
    mem_wr_data_o      = d_wr_data_i;
    mem_access_size_o  = d_access_size_i;
    if (i_gnt) begin
      mem_address_o     = i_addr_i;
      mem_wr_data_o     = '0;
      mem_access_size_o = i_access_size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      last_q  <= LAST_D;
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      last_q  <= last_d;
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  always_comb begin
    last_d  = last_q;
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    if (i_gnt) begin
      last_d = LAST_I;
    end else if (d_gnt) begin
      last_d = LAST_D;
    end
    // The nonzero guard keeps a stray response from wrapping the counter.
    case ({i_gnt, i_rsp && (i_cnt_q != '0)})
      2'b10:   i_cnt_d = i_cnt_q + CNT_W'(1);
      2'b01:   i_cnt_d = i_cnt_q - CNT_W'(1);
      default: i_cnt_d = i_cnt_q;
    endcase
    case ({d_rd_gnt, d_rsp && (d_cnt_q != '0)})
      2'b10:   d_cnt_d = d_cnt_q + CNT_W'(1);
      2'b01:   d_cnt_d = d_cnt_q - CNT_W'(1);
      default: d_cnt_d = d_cnt_q;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d, perf_c_q, perf_c_d;

  assign perf_i_d = perf_i_q + 32'(i_gnt);
  assign perf_d_d = perf_d_q + 32'(d_gnt);
  assign perf_c_d = perf_c_q + 32'(i_req_valid_i & d_req_valid_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      perf_i_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      perf_i_q <= perf_i_d;
      perf_d_q <= perf_d_d;
      perf_c_q <= perf_c_d;
    end
  end

  assign perf_i_grants_o  = perf_i_q;
  assign perf_d_grants_o  = perf_d_q;
  assign perf_conflicts_o = perf_c_q;
`endif

`ifndef SYNTHESIS
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || MEM_LATENCY < 1) begin : g_param_check
    $error("mem_arbiter: MAX_OUTSTANDING must be 1..15 and MEM_LATENCY at least 1");
  end

  a_i_rsp_credit: assert property (@(posedge clk_i) disable iff (!rst_i)
    (mem_data_valid_i && mem_data_is_instr_i) |-> (i_cnt_q != '0));
  a_d_rsp_credit: assert property (@(posedge clk_i) disable iff (!rst_i)
    (mem_data_valid_i && !mem_data_is_instr_i) |-> (d_cnt_q != '0));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory responder, queue-based reference model and directed scenarios.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int MAXO = 4;
  localparam int LAT  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          i_req_valid_i, i_req_ready_o, i_rsp_valid_o;
  logic [AW-1:0] i_addr_i;
  logic [1:0]    i_access_size_i;
  logic [DW-1:0] i_rsp_data_o;
  logic          d_req_valid_i, d_req_we_i, d_req_ready_o, d_rsp_valid_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wr_data_i, d_rsp_data_o;
  logic [1:0]    d_access_size_i;
  logic          mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [1:0]    mem_access_size_o;
  logic          mem_data_valid_i, mem_data_is_instr_i;
  logic [DW-1:0] mem_data_i;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_i_grants_o, perf_d_grants_o, perf_conflicts_o;
`endif

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .MEM_LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o), .i_addr_i(i_addr_i),
    .i_access_size_i(i_access_size_i), .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_data_o(i_rsp_data_o),
    .d_req_valid_i(d_req_valid_i), .d_req_we_i(d_req_we_i), .d_req_ready_o(d_req_ready_o),
    .d_addr_i(d_addr_i), .d_wr_data_i(d_wr_data_i), .d_access_size_i(d_access_size_i),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_data_o(d_rsp_data_o),
    .mem_rd_req_valid_o(mem_rd_req_valid_o), .mem_wr_req_valid_o(mem_wr_req_valid_o),
    .mem_req_is_instr_o(mem_req_is_instr_o), .mem_address_o(mem_address_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_access_size_o(mem_access_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
    .mem_data_i(mem_data_i)
`ifdef MEM_ARB_PERF_EN
    , .perf_i_grants_o(perf_i_grants_o), .perf_d_grants_o(perf_d_grants_o),
    .perf_conflicts_o(perf_conflicts_o)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Untouched memory lines hold {a+12, a+8, a+4, a} with A5 in each word's top byte.
  function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a} ^ {4{32'hA5000000}};
  endfunction

  // Memory responder: reads return LAT cycles after the request, writes land at the grant edge.
  bit            mflag [1024];
  logic [DW-1:0] mdata [1024];
  logic          pv [LAT];
  logic          pt [LAT];
  logic [DW-1:0] pd [LAT];
  logic [9:0]    midx;
  assign midx = mem_address_o[13:4];

  always @(posedge clk) begin
    if (!rst_i) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pt[i] <= pt[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= mem_rd_req_valid_o;
      pt[0] <= mem_req_is_instr_o;
      pd[0] <= mflag[midx] ? mdata[midx] : init_line(mem_address_o);
      if (mem_wr_req_valid_o) begin
        mflag[midx] <= 1'b1;
        mdata[midx] <= mem_wr_data_o;
      end
    end
  end

  assign mem_data_valid_i    = pv[LAT-1];
  assign mem_data_is_instr_i = pt[LAT-1];
  assign mem_data_i          = pd[LAT-1];

  // Reference model: outstanding reads per port are the pending entries of an in-order queue.
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  rsp_t          iq[$];
  rsp_t          dq[$];
  bit            m_flag [1024];
  logic [DW-1:0] m_data [1024];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [9:0] k;
    k = a[13:4];
    return m_flag[k] ? m_data[k] : init_line(a);
  endfunction

  initial begin
    bit last_d, i_due, d_due, i_el, d_el, gi, gd;
    logic [9:0] k;
    last_d = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        chk("reset_outputs_zero", {i_req_ready_o, d_req_ready_o, i_rsp_valid_o, d_rsp_valid_o,
                                   mem_rd_req_valid_o, mem_wr_req_valid_o}, '0);
        iq.delete();
        dq.delete();
        last_d = 1'b1;
      end else begin
        i_due = (iq.size() > 0) && (iq[0].due == cyc);
        d_due = (dq.size() > 0) && (dq[0].due == cyc);
        i_el  = i_req_valid_i && (iq.size() < MAXO);
        d_el  = d_req_valid_i && (d_req_we_i || (dq.size() < MAXO));
        gi    = i_el && (!d_el || last_d);
        gd    = d_el && !gi;
        chk("i_ready", i_req_ready_o, gi);
        chk("d_ready", d_req_ready_o, gd);
        chk("mem_rd_valid", mem_rd_req_valid_o, gi || (gd && !d_req_we_i));
        chk("mem_wr_valid", mem_wr_req_valid_o, gd && d_req_we_i);
        if (gi || gd) begin
          chk("mem_is_instr", mem_req_is_instr_o, gi);
          chk("mem_addr", mem_address_o, gi ? i_addr_i : d_addr_i);
          chk("mem_size", mem_access_size_o, gi ? i_access_size_i : d_access_size_i);
          chk("mem_wdata", mem_wr_data_o, gi ? '0 : d_wr_data_i);
        end
        chk("i_rsp_valid", i_rsp_valid_o, i_due);
        chk("d_rsp_valid", d_rsp_valid_o, d_due);
        if (i_due) begin
          chk("i_rsp_data", i_rsp_data_o, iq[0].data);
          void'(iq.pop_front());
        end
        if (d_due) begin
          chk("d_rsp_data", d_rsp_data_o, dq[0].data);
          void'(dq.pop_front());
        end
        if (gi) iq.push_back('{due: cyc + LAT, data: model_read(i_addr_i)});
        if (gd && !d_req_we_i) dq.push_back('{due: cyc + LAT, data: model_read(d_addr_i)});
        if (gd && d_req_we_i) begin
          k = d_addr_i[13:4];
          m_flag[k] = 1'b1;
          m_data[k] = d_wr_data_i;
        end
        if (gi) last_d = 1'b0;
        else if (gd) last_d = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req_valid_i = 1'b0;
    d_req_valid_i = 1'b0;
    d_req_we_i    = 1'b0;
  endtask

  bit exp_ci [14] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
  bit exp_cd [14] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0};

  initial begin
    bit any_rsp;
    int ngr;
    rst_i = 1'b0;
    idle();
    i_addr_i = '0; d_addr_i = '0; d_wr_data_i = '0;
    i_access_size_i = 2'd2; d_access_size_i = 2'd3;
    tick(); tick();
    i_req_valid_i = 1'b1; d_req_valid_i = 1'b1;
    #1;
    chk("reset_i_ready", i_req_ready_o, 1'b0);
    chk("reset_d_ready", d_req_ready_o, 1'b0);
    chk("reset_mem_rd", mem_rd_req_valid_o, 1'b0);
    tick(); idle(); rst_i = 1'b1;
    tick();

    // Lone I read
    i_req_valid_i = 1'b1; i_addr_i = 32'h40;
    #1;
    chk("lone_i_ready", i_req_ready_o, 1'b1);
    chk("lone_i_is_instr", mem_req_is_instr_o, 1'b1);
    tick(); idle();
    repeat (9) tick();
    #1;
    chk("lone_i_rsp_valid", i_rsp_valid_o, 1'b1);
    chk("lone_i_rsp_data", i_rsp_data_o, 128'hA500004C_A5000048_A5000044_A5000040);
    chk("lone_d_rsp_quiet", d_rsp_valid_o, 1'b0);
    tick();

    // Write then read to the same address
    d_req_valid_i = 1'b1; d_req_we_i = 1'b1; d_addr_i = 32'h100;
    d_wr_data_i = 128'h01234567_89ABCDEF_CAFEF00D_DEADBEEF;
    #1;
    chk("wr_ready", d_req_ready_o, 1'b1);
    chk("wr_mem_wr_valid", mem_wr_req_valid_o, 1'b1);
    chk("wr_mem_rd_quiet", mem_rd_req_valid_o, 1'b0);
    tick(); d_req_we_i = 1'b0;
    #1;
    chk("rd_after_wr_ready", d_req_ready_o, 1'b1);
    tick(); idle();
    repeat (9) tick();
    #1;
    chk("rd_after_wr_valid", d_rsp_valid_o, 1'b1);
    chk("rd_after_wr_data", d_rsp_data_o[31:0], 32'hDEADBEEF);
    tick();

    // D credit exhaustion; writes bypass the credit check
    for (int k = 0; k < 4; k++) begin
      d_req_valid_i = 1'b1; d_req_we_i = 1'b0; d_addr_i = 32'h200 + 32'(k * 16);
      #1;
      chk("d_fill_ready", d_req_ready_o, 1'b1);
      tick();
    end
    d_addr_i = 32'h240;
    #1;
    chk("d_credit_stall", d_req_ready_o, 1'b0);
    tick();
    d_req_we_i = 1'b1; d_addr_i = 32'h300; d_wr_data_i = 128'h5;
    #1;
    chk("d_write_no_credit", d_req_ready_o, 1'b1);
    chk("d_write_mem_wr", mem_wr_req_valid_o, 1'b1);
    tick(); idle();
    repeat (12) tick();

    // Contention from reset release
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    i_req_valid_i = 1'b1; i_addr_i = 32'h1000;
    d_req_valid_i = 1'b1; d_req_we_i = 1'b0; d_addr_i = 32'h2000;
    for (int c = 0; c < 14; c++) begin
      #1;
      chk("contention_i_ready", i_req_ready_o, exp_ci[c]);
      chk("contention_d_ready", d_req_ready_o, exp_cd[c]);
      tick();
    end
    idle();
    repeat (14) tick();

    // Reset with reads in flight
    i_req_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr_i = 32'h500 + 32'(k * 16);
      #1;
      chk("midrst_issue", i_req_ready_o, 1'b1);
      tick();
    end
    rst_i = 1'b0; d_req_valid_i = 1'b1;
    #1;
    chk("midrst_i_ready_low", i_req_ready_o, 1'b0);
    chk("midrst_d_ready_low", d_req_ready_o, 1'b0);
    tick();
    rst_i = 1'b1; idle();
    any_rsp = 1'b0;
    repeat (14) begin
      #1;
      if (i_rsp_valid_o || d_rsp_valid_o) any_rsp = 1'b1;
      tick();
    end
    chk("midrst_no_rsp", any_rsp, 1'b0);
    i_req_valid_i = 1'b1; d_req_valid_i = 1'b1; i_addr_i = 32'h600; d_addr_i = 32'h700;
    #1;
    chk("midrst_first_i", i_req_ready_o, 1'b1);
    chk("midrst_first_not_d", d_req_ready_o, 1'b0);
    tick();
    #1;
    chk("midrst_then_d", d_req_ready_o, 1'b1);
    tick(); idle();
    repeat (14) tick();

`ifdef MEM_ARB_PERF_EN
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    i_req_valid_i = 1'b1; d_req_valid_i = 1'b1; i_addr_i = 32'h800; d_addr_i = 32'h900;
    ngr = 0;
    repeat (20) begin
      #1;
      ngr += int'(i_req_ready_o) + int'(d_req_ready_o);
      tick();
    end
    idle();
    #1;
    chk("perf_conflicts", perf_conflicts_o, 32'd20);
    chk("perf_grant_sum", perf_i_grants_o + perf_d_grants_o, 32'(ngr));
    repeat (14) tick();
`else
    ngr = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the fixed-latency pipelined main memory between the instruction-fetch requester (I) and the load/store requester (D). Grants at most one request per cycle with round-robin fairness, throttles each port with an outstanding-read credit counter, and routes each memory response back to its owner by the `is_instr` tag. Sits between the cache/fetch front ends and the memory model in the multi-cycle processor.

## Interface
- `ADDR_WIDTH`, default `params_pkg::ADDR_WIDTH`: address width.
- `DATA_WIDTH`, default 128: request/response data width.
- `MAX_OUTSTANDING`, default 4: maximum in-flight reads per port, range 1..15.
- `MEM_LATENCY`, default 10: memory request-to-response cycles. Documentation only; the arbiter never counts latency.

- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset, synchronous, active-low.
- `i_req_valid_i` in 1: I read request.
- `i_req_ready_o` out 1: I request granted this cycle.
- `i_addr_i` in ADDR_WIDTH: I address.
- `i_access_size_i` in access_size_t: I access size.
- `i_rsp_valid_o` out 1: I response valid.
- `i_rsp_data_o` out DATA_WIDTH: I response data.
- `d_req_valid_i` in 1: D request.
- `d_req_we_i` in 1: D request is a write.
- `d_req_ready_o` out 1: D request granted this cycle.
- `d_addr_i` in ADDR_WIDTH: D address.
- `d_wr_data_i` in DATA_WIDTH: D write data.
- `d_access_size_i` in access_size_t: D access size.
- `d_rsp_valid_o` out 1: D read response valid.
- `d_rsp_data_o` out DATA_WIDTH: D response data.
- `mem_rd_req_valid_o`, `mem_wr_req_valid_o`, `mem_req_is_instr_o` out 1: memory request controls.
- `mem_address_o` out ADDR_WIDTH: memory request address.
- `mem_wr_data_o` out DATA_WIDTH: memory write data.
- `mem_access_size_o` out access_size_t: memory request access size.
- `mem_data_valid_i`, `mem_data_is_instr_i` in 1: memory response valid and tag.
- `mem_data_i` in DATA_WIDTH: memory response data.

## Operation
- **Eligibility.**
  - I is eligible when `i_req_valid_i` is high and `i_cnt < MAX_OUTSTANDING`.
  - D is eligible when `d_req_valid_i` is high and either `d_req_we_i` is high or `d_cnt < MAX_OUTSTANDING`. Writes consume no credit.
- **Arbitration.**
  - Only one port eligible: that port is granted.
  - Both eligible: grant goes to the port not in `last_grant`.
  - `last_grant` updates on every grant.
  - Reset value of `last_grant` is D, so I wins the first contention.
- **Issue.** Combinational from the granted port:
  - `mem_rd_req_valid_o` = grant and not write.
  - `mem_wr_req_valid_o` = D grant and `d_req_we_i`.
  - `mem_req_is_instr_o` = I grant.
  - Address, data and size are muxed from the granted port. Write data is 0 for I.
  - With no grant, all memory valids are 0.
- **Credit counters.**
  - `i_cnt` and `d_cnt` are $clog2(MAX_OUTSTANDING+1) bits wide.
  - Increment on a read grant; decrement on a matching response.
  - Increment and decrement in the same cycle: count unchanged.
  - A response returned in the same cycle does not free a credit for that cycle's eligibility check.
- **Response routing.** Combinational, no buffering; requesters must accept responses.
  - `i_rsp_valid_o` = `mem_data_valid_i & mem_data_is_instr_i`.
  - `d_rsp_valid_o` = `mem_data_valid_i & ~mem_data_is_instr_i`.
  - Data passes to both outputs unconditionally.
- **Ordering.** Memory is in-order. A D read granted any cycle after a D write to the same address returns the written data. Writes complete at grant.
- **Error.** Under `ifndef SYNTHESIS`, a simulation assertion fires on a response arriving at a port whose count is 0.

## Timing
- Grant/ready is combinational in the request cycle T.
- Read response is visible in cycle T+MEM_LATENCY (T+10).
- Peak throughput is one request per cycle.
- Sustained reads per port are limited to MAX_OUTSTANDING per MEM_LATENCY cycles.
- Reset (`rst_i` low at a clock edge):
  - `i_cnt`, `d_cnt` return to 0; `last_grant` returns to D; perf counters clear.
  - All ready/valid outputs read 0 while `rst_i` is low.
  - In-flight reads are discarded. Memory shares `rst_i` and clears its pipeline in the same edge.
- Requests held valid without ready must keep address/data stable; the arbiter does not latch them.

## Configuration
- `MEM_ARB_PERF_EN` defined: adds three 32-bit outputs `perf_i_grants_o`, `perf_d_grants_o` and `perf_conflicts_o`.
  - `perf_conflicts_o` counts cycles where both `*_req_valid_i` are high.
  - The counters wrap modulo 2^32 and reset to 0.
- Not defined: these ports and their registers are absent; the arbitration behaviour is identical.

## Test plan
- **Lone I read.** I read at addr 0x40 in cycle 5 → `i_req_ready_o`=1 in cycle 5, `mem_req_is_instr_o`=1, `i_rsp_valid_o`=1 in cycle 15 with the memory contents of 0x40..0x4F; `d_rsp_valid_o` stays 0.
- **Contention.** Both ports request continuously from reset release → grants alternate I, D, I, D…; each port is stalled after 4 reads, and resumes the cycle after its first response returns.
- **Write-then-read.** D write 0xDEADBEEF to 0x100 in cycle 3, D read 0x100 in cycle 4 → `d_rsp_data_o[31:0]`=0xDEADBEEF in cycle 14; `d_cnt` never counts the write.
- **Simultaneous inc/dec.** With `i_cnt`=4, a response and a new I request arrive in the same cycle → request stalled that cycle, granted next cycle; `i_cnt` goes 4→3→4.
- **Reset mid-operation.** 3 reads in flight, then `rst_i` low for 1 cycle → no responses delivered afterwards; counts 0; the next contention grants I first.
- **Perf counters (`MEM_ARB_PERF_EN`).** 20 cycles of both-valid → `perf_conflicts_o`=20, `perf_i_grants_o`+`perf_d_grants_o` equals the total number of grants.
